// File: rtl/modinv_pkg.sv
// Shared types and constants for the sequential modular inverse.
// Optional build macro: MODINV_PREREDUCE_EN (operands a >= m are reduced first).
package modinv_pkg;

    parameter int W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PRERED,
        RUN,
        FIN
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'd0;
    localparam status_t ST_BAD_MOD = 2'd1;
    localparam status_t ST_NOT_INV = 2'd2;
    localparam status_t ST_RANGE   = 2'd3;

endpackage

// File: rtl/mod_inverse_seq_if.sv
// Request/response bundle of the modular inverse unit.
// Ports: start/a/m (request), ready/done/status/result (response).
interface mod_inverse_seq_if
    import modinv_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic         ready;
    logic         done;
    status_t      status;
    logic [W-1:0] result;

    modport master (
        output start, a, m,
        input  ready, done, status, result
    );

    modport slave (
        input  start, a, m,
        output ready, done, status, result
    );

endinterface

// File: rtl/modinv_halve.sv
// Modular halving: x/2 mod m for odd m and x in [0, m-1].
// Ports: x_i, m_i (operands), y_o (result, also in [0, m-1]).
module modinv_halve #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] y_o
);

    // x + m can carry out of W bits, so the sum keeps one extra bit.
    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, x_i};
        if (x_i[0]) begin
            sum = {1'b0, x_i} + {1'b0, m_i};
        end
        y_o = sum[W:1];
    end

endmodule

// File: rtl/mod_inverse_seq.sv
// Binary extended-GCD modular inverse, one reduction step per clock.
// Ports: clk, rst_n (sync, active low), bus (slave side of mod_inverse_seq_if).
// Build macro MODINV_PREREDUCE_EN adds a shift-subtract a mod m stage.
module mod_inverse_seq
    import modinv_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mod_inverse_seq_if.slave      bus
);

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] u_q, u_d;
    logic [W-1:0] v_q, v_d;
    logic [W-1:0] x1_q, x1_d;
    logic [W-1:0] x2_q, x2_d;
    logic [W-1:0] res_q, res_d;
    status_t      st_q, st_d;

    logic [W-1:0] x1_half;
    logic [W-1:0] x2_half;

`ifdef MODINV_PREREDUCE_EN
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    rem_sh;
`endif

    modinv_halve #(.W(W)) u_halve_x1 (
        .x_i (x1_q),
        .m_i (m_q),
        .y_o (x1_half)
    );

    modinv_halve #(.W(W)) u_halve_x2 (
        .x_i (x2_q),
        .m_i (m_q),
        .y_o (x2_half)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        res_d   = res_q;
        st_d    = st_q;
`ifdef MODINV_PREREDUCE_EN
        cnt_d   = cnt_q;
        rem_sh  = '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    m_d     = bus.m;
                    res_d   = '0;
                    st_d    = ST_OK;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!m_q[0] || (m_q < W'(3))) begin
                    st_d    = ST_BAD_MOD;
                    state_d = FIN;
                end else if (a_q >= m_q) begin
`ifdef MODINV_PREREDUCE_EN
                    u_d     = '0;
                    cnt_d   = '0;
                    state_d = PRERED;
`else
                    st_d    = ST_RANGE;
                    state_d = FIN;
`endif
                end else if (a_q == '0) begin
                    st_d    = ST_NOT_INV;
                    state_d = FIN;
                end else begin
                    u_d     = a_q;
                    v_d     = m_q;
                    x1_d    = W'(1);
                    x2_d    = '0;
                    state_d = RUN;
                end
            end
`ifdef MODINV_PREREDUCE_EN
            PRERED: begin
                // Restoring remainder: u holds the partial remainder,
                // a shifts its bits in MSB first.
                rem_sh = {u_q, a_q[W-1]};
                if (rem_sh >= {1'b0, m_q}) begin
                    rem_sh = rem_sh - {1'b0, m_q};
                end
                u_d   = rem_sh[W-1:0];
                a_d   = a_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    a_d     = rem_sh[W-1:0];
                    u_d     = '0;
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
`endif
            RUN: begin
                if (u_q == W'(1)) begin
                    res_d   = x1_q;
                    st_d    = ST_OK;
                    state_d = FIN;
                end else if (v_q == W'(1)) begin
                    res_d   = x2_q;
                    st_d    = ST_OK;
                    state_d = FIN;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    st_d    = ST_NOT_INV;
                    state_d = FIN;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d = u_q - v_q;
                    // The true difference lies in [0, m-1]; modulo-2^W
                    // wraparound of x1 + m - x2 yields it exactly.
                    if (x1_q >= x2_q) begin
                        x1_d = x1_q - x2_q;
                    end else begin
                        x1_d = x1_q + m_q - x2_q;
                    end
                end else begin
                    v_d = v_q - u_q;
                    if (x2_q >= x1_q) begin
                        x2_d = x2_q - x1_q;
                    end else begin
                        x2_d = x2_q + m_q - x1_q;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            res_q   <= '0;
            st_q    <= ST_OK;
`ifdef MODINV_PREREDUCE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            res_q   <= res_d;
            st_q    <= st_d;
`ifdef MODINV_PREREDUCE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.done   = (state_q == FIN);
    assign bus.status = st_q;
    assign bus.result = res_q;

endmodule

// File: tb/tb_mod_inverse_seq.sv
// Scoreboard bench for mod_inverse_seq: directed vectors, queued expectations.
// A negedge monitor pops one expectation per done pulse.
module tb_mod_inverse_seq;
    import modinv_pkg::*;

    localparam int W = 32;
`ifdef MODINV_PREREDUCE_EN
    localparam int LIM = 4 * W + 4 + W + 1;
`else
    localparam int LIM = 4 * W + 4;
`endif

    typedef struct packed {
        status_t      st;
        logic [W-1:0] res;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    mod_inverse_seq_if #(.W(W)) bus ();

    mod_inverse_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (bus.done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got st=%0d res=%h, required no done",
                         bus.status, bus.result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.status !== e.st || bus.result !== e.res) begin
                    errors++;
                    $display("FAIL result: got st=%0d res=%h, required st=%0d res=%h",
                             bus.status, bus.result, e.st, e.res);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < LIM + 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", W'(bus.ready), W'(1));
    endtask

    // Issue one request; exact_lat < 0 means only the upper bound applies.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] m,
                         input status_t st, input logic [W-1:0] res,
                         input int exact_lat);
        int lat;
        exp_t e;
        wait_ready();
        e.st  = st;
        e.res = res;
        sb_q.push_back(e);
        bus.a     = a;
        bus.m     = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        chk("done_in_bound", W'(bus.done), W'(1));
        if (exact_lat >= 0) begin
            chk("latency", W'(lat), W'(exact_lat));
        end
        @(negedge clk);
        chk("ready_after_done", W'(bus.ready), W'(1));
        chk("done_pulse", W'(bus.done), W'(0));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.m     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", W'(bus.ready), W'(1));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_status", W'(bus.status), W'(0));
        chk("rst_result", bus.result, '0);

        issue(32'd3, 32'd7, ST_OK, 32'd5, -1);
        issue(32'd2, 32'hFFFF_FFFB, ST_OK, 32'h7FFF_FFFE, -1);
        issue(32'hFFFF_FFFA, 32'hFFFF_FFFB, ST_OK, 32'hFFFF_FFFA, -1);
        issue(32'd3, 32'd11, ST_OK, 32'd4, -1);
        issue(32'd1, 32'd3, ST_OK, 32'd1, -1);
        issue(32'd10, 32'd15, ST_NOT_INV, 32'd0, -1);
        issue(32'd6, 32'd9, ST_NOT_INV, 32'd0, -1);
        issue(32'd0, 32'd7, ST_NOT_INV, 32'd0, 2);
        issue(32'd5, 32'd8, ST_BAD_MOD, 32'd0, 2);
        issue(32'd1, 32'd1, ST_BAD_MOD, 32'd0, 2);
        issue(32'd4, 32'd2, ST_BAD_MOD, 32'd0, 2);
`ifdef MODINV_PREREDUCE_EN
        issue(32'd10, 32'd7, ST_OK, 32'd5, -1);
        issue(32'd7, 32'd7, ST_NOT_INV, 32'd0, W + 3);
`else
        issue(32'd10, 32'd7, ST_RANGE, 32'd0, 2);
        issue(32'd7, 32'd7, ST_RANGE, 32'd0, 2);
`endif

        // Reset in the middle of a long computation: no done may follow.
        wait_ready();
        bus.a     = 32'd3;
        bus.m     = 32'hFFFF_FFFB;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_ready", W'(bus.ready), W'(0));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", W'(bus.ready), W'(1));
        chk("abort_result", bus.result, '0);
        chk("abort_status", W'(bus.status), W'(0));
        repeat (LIM) @(negedge clk);

        // Start while busy must be ignored.
        wait_ready();
        begin
            exp_t e;
            e.st  = ST_OK;
            e.res = 32'd5;
            sb_q.push_back(e);
        end
        bus.a     = 32'd3;
        bus.m     = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.a     = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (LIM) @(negedge clk);
        chk("busy_start_ready", W'(bus.ready), W'(1));
        chk("busy_start_result", bus.result, 32'd5);

        chk("scoreboard_empty", W'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_inverse_seq.md
Name: mod_inverse_seq

Overview:
- Sequential modular multiplicative inverse: given a and odd modulus m, returns x with (a*x) mod m = 1, using the binary extended-GCD algorithm.
- Performs one reduction step per clock.
- Works in the opposite direction to the team's combinational reduction path: reduction maps number to number mod m, and this block maps a residue to its multiplicative inverse.
- Shares modulus conventions with the reduction path and sits beside it in the arithmetic datapath.

Parameters:
- W, 32, operand/result width in bits (W >= 4).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  W  operand to invert
- m  input  W  modulus; must be odd and >= 3
- ready  output  1  block idle, start accepted
- done  output  1  one-cycle pulse, result/status valid from this cycle
- status  output  2  0 OK, 1 BAD_MOD, 2 NOT_INVERTIBLE, 3 RANGE
- result  output  W  inverse in [1, m-1]; 0 when status != OK

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-low: rst_n=0 at a rising edge of clk forces the IDLE state.
  - Reset values: ready=1, done=0, status=0, result=0, all internal registers 0.
  - Reset mid-operation aborts the computation, with no done pulse.
- States: IDLE, CHECK, (PRERED), RUN, FIN.
- IDLE:
  - ready=1.
  - On start=1, latch a and m, set ready=0 and go to CHECK.
  - start is ignored whenever ready=0.
- CHECK (1 cycle), first matching rule applies:
  - m even or m<3 -> FIN with status BAD_MOD.
  - a>=m -> PRERED if the macro is defined, else FIN with status RANGE.
  - a==0 -> FIN with status NOT_INVERTIBLE.
  - Otherwise initialise u=a, v=m, x1=1, x2=0 and go to RUN.
- RUN performs one action per cycle, first matching rule applies:
  - u==1: result=x1 -> FIN, status OK.
  - v==1: result=x2 -> FIN, status OK.
  - u==0 or v==0: -> FIN, status NOT_INVERTIBLE (gcd > 1).
  - u even: u=u>>1; x1=halve(x1).
  - v even: v=v>>1; x2=halve(x2).
  - u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1+m-x2.
  - otherwise: v=v-u; x2 = x2>=x1 ? x2-x1 : x2+m-x1.
- Arithmetic rules:
  - halve(x) = x even ? x>>1 : (x+m)>>1, computed in W+1 bits with no overflow.
  - x1 and x2 always stay in [0, m-1].
  - u and v never exceed m.
- FIN (1 cycle):
  - done=1; result and status are registered in this cycle.
  - Return to IDLE with ready=1 on the next cycle.
  - result and status hold until the next accepted start.
- Latency is data-dependent:
  - start accepted -> done is at most 4*W+4 cycles.
  - Error exits take exactly 2 cycles.
  - The bench enforces the 4*W+4 bound.
- start asserted in the same cycle as done is not accepted, because ready=0 in FIN.

Optional Feature:
- Macro MODINV_PREREDUCE_EN.
- Defined:
  - CHECK routes a>=m into PRERED: a W-cycle restoring shift-subtract remainder computes a mod m.
  - PRERED then re-enters the CHECK rules with the reduced value (0 -> NOT_INVERTIBLE, else RUN).
  - Adds W+1 cycles to the latency; status RANGE is never produced.
- Undefined:
  - No PRERED state and no remainder hardware.
  - a>=m yields status RANGE after 2 cycles.

Decomposition:
- Package modinv_pkg:
  - Parameter W_DEF=32.
  - State enum (IDLE, CHECK, PRERED, RUN, FIN).
  - Status constants ST_OK, ST_BAD_MOD, ST_NOT_INV, ST_RANGE.
- Sub-module modinv_halve: combinational halve(x, m), W+1-bit internal sum.
  - Instantiated twice, once for x1 and once for x2.
- The remainder datapath stays inline, guarded by the macro.

Test Plan:
- a=3, m=7, start pulse -> done within 132 cycles, status=0, result=5; ready returns 1 the cycle after done.
- a=2, m=0xFFFFFFFB -> status=0, result=0x7FFFFFFE.
- a=10, m=15 -> status=2 (NOT_INVERTIBLE), result=0.
- Bad-modulus cases:
  - a=5, m=8 -> status=1, done exactly 2 cycles after start.
  - a=1, m=1 -> status=1.
- a=10, m=7:
  - With MODINV_PREREDUCE_EN -> status=0, result=5.
  - Without it -> status=3 after 2 cycles.
- Control:
  - Drive rst_n=0 for 1 cycle mid-RUN on a=3, m=0xFFFFFFFB -> no done pulse, ready=1, result=0 next cycle.
  - Pulse start while busy with a different a -> ignored; original result is delivered.
